// File: rtl/segment_demod_decider.sv
// Hamming-distance demodulator: accumulates distance of received segments to the
// if/else reference segments, decides one bit per SEGS_PER_BIT segments and packs
// BITS_PER_WORD bits into a valid/ready output word.
// Optional macro ERASURE_FLAG_EN adds an erasure_mask output that flags tied decisions.
module segment_demod_decider #(
    parameter int SEGS_PER_BIT  = 4,
    parameter int BITS_PER_WORD = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] segment_in,
    input  logic        seg_valid,
    output logic        seg_ready,
    input  logic [31:0] array_ref_wire,
    input  logic [31:0] array_ref_m_wire,
    output logic [31:0] output_bits,
    output logic        out_valid,
`ifdef ERASURE_FLAG_EN
    output logic [31:0] erasure_mask,
`endif
    input  logic        out_ready
);

    localparam int ACC_W = $clog2(32 * SEGS_PER_BIT + 1);
    localparam int CNT_W = $clog2(SEGS_PER_BIT + 1);
    localparam int BIT_W = $clog2(BITS_PER_WORD + 1);

    typedef enum logic [1:0] {
        ST_ACCUM    = 2'd0,
        ST_DECIDE   = 2'd1,
        ST_OUT_HOLD = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ACC_W-1:0]         acc_if_q, acc_if_d;
    logic [ACC_W-1:0]         acc_else_q, acc_else_d;
    logic [CNT_W-1:0]         seg_cnt_q, seg_cnt_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic [31:0]              out_bits_q, out_bits_d;
    logic                     out_valid_q, out_valid_d;

    logic                     transfer;
    logic                     decided_bit;
    logic [5:0]               dist_if;
    logic [5:0]               dist_else;
    logic [BITS_PER_WORD-1:0] shift_next;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    assign seg_ready   = (state_q == ST_ACCUM) && !reset;
    assign transfer    = seg_valid && seg_ready;
    assign dist_if     = popcount32(segment_in ^ array_ref_wire);
    assign dist_else   = popcount32(segment_in ^ array_ref_m_wire);
    // A tie favours the if-path, so the comparison is inclusive.
    assign decided_bit = (acc_if_q <= acc_else_q);
    assign shift_next  = (shift_q << 1) | BITS_PER_WORD'(decided_bit);

    assign output_bits = out_bits_q;
    assign out_valid   = out_valid_q;

`ifdef ERASURE_FLAG_EN
    logic [BITS_PER_WORD-1:0] er_shift_q, er_shift_d;
    logic [31:0]              er_mask_q, er_mask_d;
    logic [BITS_PER_WORD-1:0] er_shift_next;

    assign er_shift_next = (er_shift_q << 1) | BITS_PER_WORD'(acc_if_q == acc_else_q);
    assign erasure_mask  = er_mask_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ACCUM;
            acc_if_q    <= '0;
            acc_else_q  <= '0;
            seg_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_bits_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef ERASURE_FLAG_EN
            er_shift_q  <= '0;
            er_mask_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_if_q    <= acc_if_d;
            acc_else_q  <= acc_else_d;
            seg_cnt_q   <= seg_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_bits_q  <= out_bits_d;
            out_valid_q <= out_valid_d;
`ifdef ERASURE_FLAG_EN
            er_shift_q  <= er_shift_d;
            er_mask_q   <= er_mask_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_if_d    = acc_if_q;
        acc_else_d  = acc_else_q;
        seg_cnt_d   = seg_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_bits_d  = out_bits_q;
        out_valid_d = out_valid_q;
`ifdef ERASURE_FLAG_EN
        er_shift_d  = er_shift_q;
        er_mask_d   = er_mask_q;
`endif
        case (state_q)
            ST_ACCUM: begin
                if (transfer) begin
                    acc_if_d   = acc_if_q + ACC_W'(dist_if);
                    acc_else_d = acc_else_q + ACC_W'(dist_else);
                    seg_cnt_d  = seg_cnt_q + CNT_W'(1);
                    if (seg_cnt_q == CNT_W'(SEGS_PER_BIT - 1)) begin
                        state_d = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                acc_if_d   = '0;
                acc_else_d = '0;
                seg_cnt_d  = '0;
                if (bit_cnt_q == BIT_W'(BITS_PER_WORD - 1)) begin
                    out_bits_d  = 32'(shift_next);
                    out_valid_d = 1'b1;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
`ifdef ERASURE_FLAG_EN
                    er_mask_d   = 32'(er_shift_next);
                    er_shift_d  = '0;
`endif
                    state_d     = ST_OUT_HOLD;
                end else begin
                    bit_cnt_d   = bit_cnt_q + BIT_W'(1);
                    shift_d     = shift_next;
`ifdef ERASURE_FLAG_EN
                    er_shift_d  = er_shift_next;
`endif
                    state_d     = ST_ACCUM;
                end
            end
            ST_OUT_HOLD: begin
                // Word stays frozen until the consumer takes it; output_bits is retained afterwards.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_segment_demod_decider.sv
// Self-checking bench for segment_demod_decider: randomized segments/references checked
// against a distance-sum reference model, plus directed clean/noise/tie/reset cases.
module tb_segment_demod_decider;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] segment_in, array_ref_wire, array_ref_m_wire, output_bits;
    logic        seg_valid, seg_ready, out_valid, out_ready;
    logic [31:0] sm_segment_in, sm_ref_if, sm_ref_else, sm_output_bits;
    logic        sm_seg_valid, sm_seg_ready, sm_out_valid, sm_out_ready;
`ifdef ERASURE_FLAG_EN
    logic [31:0] erasure_mask, sm_erasure_mask;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] word_q[$];
    logic [31:0] erase_q[$];
    logic [31:0] sm_word_q[$];
    logic [31:0] stim_seg[$];
    logic [31:0] stim_if[$];
    logic [31:0] stim_else[$];

    always #5 clk = ~clk;

    segment_demod_decider #(.SEGS_PER_BIT(4), .BITS_PER_WORD(32)) dut (
        .clk(clk), .reset(reset),
        .segment_in(segment_in), .seg_valid(seg_valid), .seg_ready(seg_ready),
        .array_ref_wire(array_ref_wire), .array_ref_m_wire(array_ref_m_wire),
        .output_bits(output_bits), .out_valid(out_valid),
`ifdef ERASURE_FLAG_EN
        .erasure_mask(erasure_mask),
`endif
        .out_ready(out_ready)
    );

    segment_demod_decider #(.SEGS_PER_BIT(1), .BITS_PER_WORD(4)) dut_small (
        .clk(clk), .reset(reset),
        .segment_in(sm_segment_in), .seg_valid(sm_seg_valid), .seg_ready(sm_seg_ready),
        .array_ref_wire(sm_ref_if), .array_ref_m_wire(sm_ref_else),
        .output_bits(sm_output_bits), .out_valid(sm_out_valid),
`ifdef ERASURE_FLAG_EN
        .erasure_mask(sm_erasure_mask),
`endif
        .out_ready(sm_out_ready)
    );

    // Capture every completed output handshake.
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) begin
            word_q.push_back(output_bits);
`ifdef ERASURE_FLAG_EN
            erase_q.push_back(erasure_mask);
`endif
            $display("[TB] word out 0x%08h", output_bits);
        end
        if (!reset && sm_out_valid && sm_out_ready) begin
            sm_word_q.push_back(sm_output_bits);
            $display("[TB] small word out 0x%08h", sm_output_bits);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: per bit, sum the Hamming distances to each reference; smaller-or-equal if-distance means 1.
    task automatic model_word(input int first, input int spb, input int bpw,
                              output logic [31:0] word, output logic [31:0] er);
        int di, de, idx;
        word = 0;
        er   = 0;
        for (int b = 0; b < bpw; b++) begin
            di = 0;
            de = 0;
            for (int s = 0; s < spb; s++) begin
                idx = first + b * spb + s;
                di += $countones(stim_seg[idx] ^ stim_if[idx]);
                de += $countones(stim_seg[idx] ^ stim_else[idx]);
            end
            word = (word << 1) | ((di <= de) ? 32'd1 : 32'd0);
            er   = (er << 1) | ((di == de) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic clear_stim();
        stim_seg.delete();
        stim_if.delete();
        stim_else.delete();
        word_q.delete();
        erase_q.delete();
    endtask

    task automatic push_stim(input logic [31:0] s, input logic [31:0] ri, input logic [31:0] re);
        stim_seg.push_back(s);
        stim_if.push_back(ri);
        stim_else.push_back(re);
    endtask

    // Present one segment (after optional random idle cycles) and hold it until accepted.
    task automatic send_seg(input logic [31:0] s, input logic [31:0] ri, input logic [31:0] re,
                            input int gap_pct);
        int n;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            seg_valid        = 1'b0;
            segment_in       = $urandom;
            array_ref_wire   = $urandom;
            array_ref_m_wire = $urandom;
            @(negedge clk);
        end
        seg_valid        = 1'b1;
        segment_in       = s;
        array_ref_wire   = ri;
        array_ref_m_wire = re;
        n = 0;
        while (!seg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL seg_accept_timeout: seg_ready=%0b after %0d cycles, required 1", seg_ready, n);
        end else begin
            @(negedge clk);
        end
        seg_valid        = 1'b0;
        segment_in       = $urandom;
        array_ref_wire   = $urandom;
        array_ref_m_wire = $urandom;
    endtask

    task automatic send_range(input int first, input int count, input int gap_pct);
        for (int i = 0; i < count; i++) begin
            send_seg(stim_seg[first + i], stim_if[first + i], stim_else[first + i], gap_pct);
        end
    endtask

    task automatic wait_words(input int nwords, input int maxc, output bit ok);
        int n;
        n = 0;
        while (word_q.size() < nwords && n < maxc) begin
            @(negedge clk);
            n++;
        end
        ok = (word_q.size() >= nwords);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (seg_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_seg_ready: got %0b, required 0", seg_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid);
        end
        tests_run++;
        if (output_bits !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_output_bits: got 0x%08h, required 0x00000000", output_bits);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (seg_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_seg_ready: got %0b, required 1", seg_ready);
        end
        @(negedge clk);
        $display("[TB] test_reset done");
    endtask

    task automatic test_clean();
        clear_stim();
        for (int b = 0; b < 32; b++) begin
            for (int s = 0; s < 4; s++) begin
                push_stim((b % 2 == 0) ? 32'hFFFF_FFFF : 32'h0, 32'hFFFF_FFFF, 32'h0);
            end
        end
        send_range(0, 128, 0);
        // Now in the cycle after the 128th accept: DECIDE.
        tests_run++;
        if (out_valid !== 1'b0 || seg_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL clean_decide_cycle: out_valid=%0b seg_ready=%0b, required 0/0", out_valid, seg_ready);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || output_bits !== 32'hAAAA_AAAA) begin
            tests_failed++;
            $display("[TB] FAIL clean_word: out_valid=%0b output_bits=0x%08h, required 1/0xaaaaaaaa", out_valid, output_bits);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || seg_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL clean_one_cycle: out_valid=%0b seg_ready=%0b, required 0/1", out_valid, seg_ready);
        end
        tests_run++;
        if (word_q.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL clean_word_count: got %0d, required 1", word_q.size());
        end
        $display("[TB] test_clean done");
    endtask

    task automatic test_noise();
        bit ok;
        clear_stim();
        for (int b = 0; b < 32; b++) begin
            for (int s = 0; s < 4; s++) begin
                push_stim((b < 16) ? 32'hFFFF_FF80 : 32'h0000_007F, 32'hFFFF_FFFF, 32'h0);
            end
        end
        send_range(0, 128, 0);
        wait_words(1, 20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL noise_timeout: got %0d words, required 1", word_q.size());
        end else if (word_q[0] !== 32'hFFFF_0000) begin
            tests_failed++;
            $display("[TB] FAIL noise_word: got 0x%08h, required 0xffff0000", word_q[0]);
        end
        $display("[TB] test_noise done");
    endtask

    task automatic test_tie();
        bit ok;
        clear_stim();
        for (int i = 0; i < 128; i++) push_stim(32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0);
        send_range(0, 128, 0);
        wait_words(1, 20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL tie_timeout: got %0d words, required 1", word_q.size());
        end else if (word_q[0] !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL tie_word: got 0x%08h, required 0xffffffff", word_q[0]);
        end
`ifdef ERASURE_FLAG_EN
        tests_run++;
        if (erase_q.size() < 1 || erase_q[0] !== 32'hFFFF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL tie_erasure: got 0x%08h, required 0xffffffff", erasure_mask);
        end
`endif
        $display("[TB] test_tie done");
    endtask

    task automatic test_backpressure();
        logic [31:0] w1, w2, e1, e2;
        int n;
        bit ok;
        clear_stim();
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) push_stim($urandom, $urandom, $urandom);
        model_word(0, 4, 32, w1, e1);
        model_word(128, 4, 32, w2, e2);
        send_range(0, 128, 50);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_out_valid: got %0b, required 1", out_valid);
        end
        // Offer the next word's first segment during the hold; it must not be taken.
        seg_valid        = 1'b1;
        segment_in       = stim_seg[128];
        array_ref_wire   = stim_if[128];
        array_ref_m_wire = stim_else[128];
        for (int k = 0; k < 10; k++) begin
            tests_run++;
            if (out_valid !== 1'b1 || output_bits !== w1 || seg_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold[%0d]: out_valid=%0b output_bits=0x%08h seg_ready=%0b, required 1/0x%08h/0",
                         k, out_valid, output_bits, seg_ready, w1);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || output_bits !== w1) begin
            tests_failed++;
            $display("[TB] FAIL bp_after_handshake: out_valid=%0b output_bits=0x%08h, required 0/0x%08h", out_valid, output_bits, w1);
        end
        send_range(128, 128, 50);
        wait_words(2, 20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL bp_timeout: got %0d words, required 2", word_q.size());
        end else if (word_q[0] !== w1 || word_q[1] !== w2) begin
            tests_failed++;
            $display("[TB] FAIL bp_words: got 0x%08h 0x%08h, required 0x%08h 0x%08h", word_q[0], word_q[1], w1, w2);
        end
`ifdef ERASURE_FLAG_EN
        tests_run++;
        if (erase_q.size() < 2 || erase_q[0] !== e1 || erase_q[1] !== e2) begin
            tests_failed++;
            $display("[TB] FAIL bp_erasure: got 0x%08h, required 0x%08h 0x%08h", erasure_mask, e1, e2);
        end
`endif
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_reset_mid();
        logic [31:0] w, e;
        bit ok;
        clear_stim();
        for (int i = 0; i < 22; i++) push_stim($urandom, $urandom, $urandom);
        send_range(0, 22, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (seg_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_seg_ready: got %0b, required 0", seg_ready);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || output_bits !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_outputs: out_valid=%0b output_bits=0x%08h, required 0/0x00000000", out_valid, output_bits);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (seg_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_release: seg_ready=%0b, required 1", seg_ready);
        end
        @(negedge clk);
        clear_stim();
        for (int i = 0; i < 128; i++) push_stim($urandom, $urandom, $urandom);
        model_word(0, 4, 32, w, e);
        send_range(0, 128, 20);
        wait_words(1, 20, ok);
        tests_run++;
        if (!ok || word_q.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_word_count: got %0d, required 1", word_q.size());
        end else if (word_q[0] !== w) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_word: got 0x%08h, required 0x%08h", word_q[0], w);
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_small_params();
        logic [31:0] w, e;
        logic [3:0]  pattern;
        int n;
        sm_word_q.delete();
        for (int r = 0; r < 4; r++) begin
            clear_stim();
            pattern = 4'b1011;
            for (int i = 0; i < 4; i++) begin
                if (r == 0) push_stim(pattern[3 - i] ? 32'hFFFF_FFFF : 32'h0, 32'hFFFF_FFFF, 32'h0);
                else        push_stim($urandom, $urandom, $urandom);
            end
            model_word(0, 1, 4, w, e);
            for (int i = 0; i < 4; i++) begin
                sm_seg_valid  = 1'b1;
                sm_segment_in = stim_seg[i];
                sm_ref_if     = stim_if[i];
                sm_ref_else   = stim_else[i];
                n = 0;
                while (!sm_seg_ready && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                sm_seg_valid = 1'b0;
            end
            n = 0;
            while (sm_word_q.size() < r + 1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            tests_run++;
            if (sm_word_q.size() != r + 1) begin
                tests_failed++;
                $display("[TB] FAIL small_word_count[%0d]: got %0d, required %0d", r, sm_word_q.size(), r + 1);
            end else if (sm_word_q[r] !== ((r == 0) ? 32'h0000_000B : w)) begin
                tests_failed++;
                $display("[TB] FAIL small_word[%0d]: got 0x%08h, required 0x%08h", r, sm_word_q[r], (r == 0) ? 32'h0000_000B : w);
            end
`ifdef ERASURE_FLAG_EN
            tests_run++;
            if (sm_erasure_mask !== e) begin
                tests_failed++;
                $display("[TB] FAIL small_erasure[%0d]: got 0x%08h, required 0x%08h", r, sm_erasure_mask, e);
            end
`endif
        end
        $display("[TB] test_small_params done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[3];
        logic [31:0] e;
        bit ok;
        clear_stim();
        out_ready = 1'b1;
        for (int i = 0; i < 384; i++) push_stim($urandom, $urandom, $urandom);
        for (int k = 0; k < 3; k++) model_word(k * 128, 4, 32, w[k], e);
        send_range(0, 384, 0);
        wait_words(3, 20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL b2b_timeout: got %0d words, required 3", word_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (word_q[k] !== w[k]) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_word[%0d]: got 0x%08h, required 0x%08h", k, word_q[k], w[k]);
                end
            end
        end
        $display("[TB] test_back_to_back done");
    endtask

    initial begin
        reset            = 1'b1;
        seg_valid        = 1'b0;
        segment_in       = '0;
        array_ref_wire   = '0;
        array_ref_m_wire = '0;
        out_ready        = 1'b1;
        sm_seg_valid     = 1'b0;
        sm_segment_in    = '0;
        sm_ref_if        = '0;
        sm_ref_else      = '0;
        sm_out_ready     = 1'b1;
        @(negedge clk);
        test_reset();
        test_clean();
        test_noise();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_small_params();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/segment_demod_decider.md
Name: segment_demod_decider

Overview:
- Receive-side counterpart of the if/else segment modulator.
- Takes a stream of 32-bit received segments and the same two reference segments the modulator selects between (if-path reference, else-path reference).
- Accumulates Hamming distance to each reference over SEGS_PER_BIT segments and decides the transmitted input bit.
- Packs decided bits into a word and hands it out with a valid/ready handshake.

Parameters:
- SEGS_PER_BIT, 4: segments accumulated per decided bit; legal range 1..64.
- BITS_PER_WORD, 32: decided bits per output word; legal range 1..32.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- segment_in  in  32  received segment.
- seg_valid  in  1  segment_in valid this cycle.
- seg_ready  out  1  block accepts segment; transfer when seg_valid && seg_ready.
- array_ref_wire  in  32  if-path reference segment (bit = 1).
- array_ref_m_wire  in  32  else-path reference segment (bit = 0).
- output_bits  out  32  packed decided bits; unused high bits are 0.
- out_valid  out  1  output_bits holds a complete word.
- out_ready  in  1  consumer accepts word.

Behaviour:
- Accumulator width ACC_W = clog2(32*SEGS_PER_BIT+1), unsigned; it never overflows.
- States are ACCUM, DECIDE and OUT_HOLD; the reset state is ACCUM.
- Reset: synchronous.
  - Clears acc_if, acc_else, seg_cnt, bit_cnt, the shift register, output_bits = 0 and out_valid = 0.
  - seg_ready is 0 while reset is high.
  - Reset mid-operation discards the partial bit and partial word with no output.
- ACCUM:
  - seg_ready = 1.
  - On each transfer:
    - acc_if += popcount(segment_in ^ array_ref_wire).
    - acc_else += popcount(segment_in ^ array_ref_m_wire).
    - seg_cnt++.
  - References are sampled only on transfer cycles and may change between segments.
  - If the transfer makes seg_cnt reach SEGS_PER_BIT, go to DECIDE.
  - Cycles with seg_valid = 0 change nothing.
- DECIDE (exactly 1 cycle, seg_ready = 0):
  - bit = (acc_if <= acc_else); a tie decides 1.
  - Shift register shifts left with the new bit into bit 0, so the first decided bit ends at bit BITS_PER_WORD-1.
  - Clear acc_if, acc_else and seg_cnt; increment bit_cnt.
  - If bit_cnt reaches BITS_PER_WORD:
    - Load output_bits from the shifted value (upper 32-BITS_PER_WORD bits zero).
    - Set out_valid = 1, clear bit_cnt and the shift register, go to OUT_HOLD.
  - Otherwise return to ACCUM.
- OUT_HOLD:
  - seg_ready = 0.
  - output_bits and out_valid are held stable until out_valid && out_ready.
  - On that cycle, out_valid goes to 0 next cycle and the state returns to ACCUM.
  - output_bits keeps its last value after the handshake.
- Latency: last segment of a word accepted in cycle T → DECIDE in T+1 → out_valid = 1 from T+2. Earliest next segment acceptance is the cycle after the handshake.
- No segment is dropped or duplicated under any seg_valid/out_ready pattern. seg_valid while seg_ready = 0 is ignored, and the source must hold it.
- SEGS_PER_BIT = 1: every accepted segment produces a DECIDE cycle.

Optional Feature:
- Macro: ERASURE_FLAG_EN.
- Defined:
  - Extra output port erasure_mask (out, 32) is packed in parallel with output_bits: bit = 1 when acc_if == acc_else at decision.
  - Loaded, held and reset exactly like output_bits.
  - The tied bit is still decided as 1.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Clean alternating bits, defaults, array_ref_wire = 0xFFFFFFFF, array_ref_m_wire = 0x00000000.
  - Stimulus: 4 segments of 0xFFFFFFFF then 4 of 0x00000000, repeated for 32 bits, seg_valid always 1, out_ready = 1.
  - Required: output_bits = 0xAAAAAAAA, out_valid high 1 cycle, 2 cycles after the 128th segment accept.
- Noise tolerance, same refs.
  - Stimulus: every segment carries 7 flipped bits (e.g. 0xFFFFFF80 for 1, 0x0000007F for 0), 16 ones then 16 zeros.
  - Required: output_bits = 0xFFFF0000.
- Tie.
  - Stimulus: all segments 0x0000FFFF (acc_if = acc_else = 64 per bit).
  - Required: output_bits = 0xFFFFFFFF; with ERASURE_FLAG_EN, erasure_mask = 0xFFFFFFFF.
- Backpressure and gaps.
  - Stimulus: seg_valid randomly low 50% of cycles; out_ready held 0 for 10 cycles after out_valid.
  - Required: output_bits stable and seg_ready = 0 throughout the hold; second word correct with no segment lost.
- Reset mid-bit.
  - Stimulus: assert reset 1 cycle after 2 segments of bit 5.
  - Required: out_valid = 0 and output_bits = 0 the next cycle; seg_ready = 0 during reset, 1 after; the next word starts from bit 0 and decodes correctly.
- Small parameters.
  - Stimulus: SEGS_PER_BIT = 1, BITS_PER_WORD = 4, segments 1,0,1,1.
  - Required: output_bits = 0x0000000B.
